// File: rtl/seq_shift_unit.sv
// seq_shift_unit: iterative 32-bit shifter (SLL/SRL/SRA/ROR), one bit position
// per clock, with a start/busy/done handshake for the control unit.
//
// state | meaning
// IDLE  | waiting for start; result holds the last value
// SHIFT | one 1-bit step per edge until count reaches 1
// DONE  | single-cycle done pulse; a new start may be accepted here
module seq_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] step;
  logic             accept;

  // Requests are only taken when not mid-shift; starts during SHIFT are dropped.
  assign accept = start && (state_q != SHIFT);

  // One-bit step of the working register for the latched operation.
  always_comb begin
    step = work_q;
    case (op_q)
      OP_SLL:  step = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      OP_ROR:  step = {work_q[0], work_q[WIDTH-1:1]};
      default: step = work_q;
    endcase
  end

  // Next-state logic: load on accept, step in SHIFT, DONE returns to IDLE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    case (state_q)
      SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (accept) begin
      op_d    = op;
      work_d  = data_in;
      cnt_d   = shamt;
      state_d = (shamt == '0) ? DONE : SHIFT;
    end
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_SLL;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = work_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed testbench for seq_shift_unit with hand-computed expected values.
module tb_seq_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  seq_shift_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one request, then measure latency, busy cycles and result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp);
    int n;
    int busy_cnt;
    logic [31:0] held;
    @(negedge clk);
    op = o; data_in = d; shamt = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; data_in = ~d; shamt = ~s; op = ~o;
    n = 0; busy_cnt = 0;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_lat"}, 32'(n), 32'(s));
    check_eq({tag, "_busy"}, 32'(busy_cnt), 32'(s));
    check_eq({tag, "_res"}, result, exp);
    held = result;
    @(posedge clk); #1;
    check_eq({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_hold"}, result, held);
  endtask

  initial begin
    int n;
    int pulses;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; data_in = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("sll2",    2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004);
    run_op("srl4",    2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000);
    run_op("sra31",   2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_op("sra4pos", 2'b10, 32'h4000_0000, 5'd4,  32'h0400_0000);
    run_op("ror1",    2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000);
    run_op("ror8",    2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456);
    run_op("sll31",   2'b00, 32'h8000_0001, 5'd31, 32'h8000_0000);
    run_op("zero",    2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);

    // Start pulsed mid-shift must be ignored.
    @(negedge clk);
    op = 2'b01; data_in = 32'h0000_00F0; shamt = 5'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op = 2'b00; data_in = 32'hFFFF_FFFF; shamt = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        check_eq("ign_res", result, 32'h0000_0000);
      end
    end
    check_eq("ign_pulses", 32'(pulses), 32'd1);

    // Back-to-back: second start issued during the DONE cycle.
    @(negedge clk);
    op = 2'b00; data_in = 32'h0000_0001; shamt = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("b2b_a_lat", 32'(n), 32'd3);
    check_eq("b2b_a_res", result, 32'h0000_0008);
    op = 2'b11; data_in = 32'h0000_0003; shamt = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("b2b_gap_done", {31'd0, done}, 32'd0);
    check_eq("b2b_gap_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("b2b_b_lat", 32'(n), 32'd2);
    check_eq("b2b_b_res", result, 32'hC000_0000);

    // Asynchronous reset mid-shift.
    @(negedge clk);
    op = 2'b10; data_in = 32'h8000_0000; shamt = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_done", {31'd0, done}, 32'd0);
    check_eq("arst_result", result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check_eq("arst_no_done", 32'(pulses), 32'd0);
    run_op("post_rst", 2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Iterative 32-bit shift unit for the CPU datapath, covering the right-shift direction that the fixed left-by-2 address shifter does not.
- Executes SLL/SRL/SRA/ROR by a variable 5-bit amount, one bit position per clock.
- Uses a start/busy/done handshake; the control unit stalls on busy.
- Sits beside the ALU and serves shift-class instructions.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.
- SHW, 5, shift-amount width. Must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled on rising edge.
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
- data_in  input  32  operand; sampled with start.
- shamt  input  5  shift amount 0..31; sampled with start.
- busy  output  1  high while shifting; start is ignored while high.
- done  output  1  one-cycle pulse; result valid.
- result  output  32  shifted value.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy=0, done=0, result=0, internal count=0.
  - Any in-flight operation is discarded; no done is produced.
  - Deassertion takes effect at the next clock edge.
- States: IDLE, SHIFT, DONE.
- Start acceptance:
  - start is accepted at an edge when state is IDLE or DONE.
  - On acceptance, latch op, working register <= data_in, count <= shamt.
  - If shamt==0, next state is DONE; otherwise next state is SHIFT.
- SHIFT:
  - Each edge performs exactly one 1-bit step on the working register and decrements count.
  - SLL: {w[30:0],1'b0}.
  - SRL: {1'b0,w[31:1]}.
  - SRA: {w[31],w[31:1]} (sign bit replicated).
  - ROR: {w[0],w[31:1]}.
  - When count==1 at the edge, the step completes and next state is DONE.
  - start asserted in SHIFT is ignored and not queued.
- DONE:
  - Lasts exactly one cycle, then IDLE, unless start is accepted in that same cycle. In that case load the new operands and go to SHIFT or DONE as above (back-to-back issue).
- Outputs:
  - busy = (state==SHIFT).
  - done = (state==DONE), registered, high for exactly one cycle per accepted start.
- Latency:
  - start accepted at edge k → done high in the cycle after edge k+shamt.
  - Examples: shamt=0 gives done after edge k; shamt=31 gives done after edge k+31.
- result:
  - Driven from the working register.
  - Intermediate values are visible during SHIFT and are not architecturally valid.
  - Valid while done=1, and held stable in IDLE until the next accepted start.
- Widths: all arithmetic is 32-bit. No overflow or flag outputs; bits shifted out are discarded, except ROR, which recirculates them.
- Operand changes while busy have no effect; only the values sampled at acceptance matter.

Test Plan:
- Reset, then SLL data_in=0x00000001, shamt=2 → busy high for 2 cycles, done pulse 2 cycles after start edge, result=0x00000004.
- SRL 0x80000000 by 4 → result=0x08000000, done after 4 shift cycles. SRA 0x80000000 by 31 → result=0xFFFFFFFF, done after 31 cycles.
- ROR 0x00000001 by 1 → 0x80000000. Shamt=0, any op, data 0xDEADBEEF → result=0xDEADBEEF, busy never high, done the cycle after start.
- Start SRL 0x000000F0 by 8; pulse start with SLL 0xFFFFFFFF by 1 mid-shift → second request ignored, result=0x00000000 from the first op only, a single done pulse.
- Back-to-back: new start issued during the DONE cycle → accepted with no IDLE gap, both results correct, two distinct done pulses.
- rst_n asserted low asynchronously mid-shift (SRA by 20, after 5 cycles) → busy/done/result go to 0 immediately and no done ever appears; a fresh request after release completes normally.
